// File: rtl/core_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package core_ifu_pkg;

    localparam int unsigned InstByteBus    = 32;
    localparam int unsigned InstAddressBus = 32;

    localparam logic [InstByteBus-1:0]    ZeroWord         = 32'h0000_0000;
    localparam logic [InstByteBus-1:0]    INST_NOP         = 32'h0000_0013;
    localparam logic [InstAddressBus-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [InstAddressBus-1:0] addr;
        logic [InstByteBus-1:0]    data;
    } fetch_slot_t;

    function automatic logic [InstAddressBus-1:0] word_align(input logic [InstAddressBus-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/core_ifu_queue.sv
// In-order fetch slot queue: allocate at tail, fill oldest unfilled, pop head, flush all.
module core_ifu_queue
    import core_ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush_i,
    input  logic                                alloc_i,
    input  logic [InstAddressBus-1:0]           alloc_addr_i,
    input  logic                                fill_i,
    input  logic [InstByteBus-1:0]              fill_data_i,
    input  logic                                pop_i,
    output logic                                head_valid_c,
    output logic [InstAddressBus-1:0]           head_addr_c,
    output logic [InstByteBus-1:0]              head_data_c,
    output logic [$clog2(DEPTH):0]              alloc_cnt_c,
    output logic [$clog2(DEPTH):0]              unfilled_cnt_c
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_slot_t        slot_q [DEPTH];
    fetch_slot_t        slot_d [DEPTH];
    logic [DEPTH-1:0]   filled_q, filled_d;
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [PW-1:0]      fill_ptr_q, fill_ptr_d;
    logic [CW-1:0]      alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0]      unfilled_q, unfilled_d;

    logic               do_alloc_c;
    logic               do_fill_c;
    logic               do_pop_c;

    assign head_valid_c   = (alloc_cnt_q != '0) && filled_q[head_q];
    assign head_addr_c    = slot_q[head_q].addr;
    assign head_data_c    = slot_q[head_q].data;
    assign alloc_cnt_c    = alloc_cnt_q;
    assign unfilled_cnt_c = unfilled_q;

    // A fill with nothing outstanding is a stray response and is dropped.
    assign do_alloc_c = alloc_i && (alloc_cnt_q != CW'(DEPTH));
    assign do_fill_c  = fill_i && (unfilled_q != '0);
    assign do_pop_c   = pop_i && head_valid_c;

    always_comb begin
        slot_d      = slot_q;
        filled_d    = filled_q;
        head_d      = head_q;
        tail_d      = tail_q;
        fill_ptr_d  = fill_ptr_q;
        alloc_cnt_d = alloc_cnt_q;
        unfilled_d  = unfilled_q;

        if (flush_i) begin
            filled_d    = '0;
            head_d      = '0;
            tail_d      = '0;
            fill_ptr_d  = '0;
            alloc_cnt_d = '0;
            unfilled_d  = '0;
        end else begin
            if (do_pop_c) begin
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PW'(1);
            end
            if (do_fill_c) begin
                slot_d[fill_ptr_q].data = fill_data_i;
                filled_d[fill_ptr_q]    = 1'b1;
                fill_ptr_d              = fill_ptr_q + PW'(1);
            end
            if (do_alloc_c) begin
                slot_d[tail_q].addr = alloc_addr_i;
                slot_d[tail_q].data = ZeroWord;
                filled_d[tail_q]    = 1'b0;
                tail_d              = tail_q + PW'(1);
            end
            alloc_cnt_d = alloc_cnt_q + CW'(do_alloc_c) - CW'(do_pop_c);
            unfilled_d  = unfilled_q + CW'(do_alloc_c) - CW'(do_fill_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '{default: '0};
            filled_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            fill_ptr_q  <= '0;
            alloc_cnt_q <= '0;
            unfilled_q  <= '0;
        end else begin
            slot_q      <= slot_d;
            filled_q    <= filled_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            fill_ptr_q  <= fill_ptr_d;
            alloc_cnt_q <= alloc_cnt_d;
            unfilled_q  <= unfilled_d;
        end
    end

endmodule

// File: rtl/core_ifu.sv
// Instruction fetch unit: PC, fetch issue, redirect flush and stale-response discard.
module core_ifu
    import core_ifu_pkg::*;
#(
    parameter logic [InstAddressBus-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned               DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      jump_en_in,
    input  logic [InstAddressBus-1:0] jump_addr_in,
    input  logic                      stall_in,
    output logic                      mem_req_out,
    output logic [InstAddressBus-1:0] mem_addr_out,
    input  logic                      mem_ready_in,
    input  logic                      mem_rvalid_in,
    input  logic [InstByteBus-1:0]    mem_rdata_in,
    output logic                      inst_valid_out,
    output logic [InstByteBus-1:0]    inst_out,
    output logic [InstAddressBus-1:0] inst_addr_out
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [InstAddressBus-1:0] pc_q, pc_d;
    logic [CW-1:0]             discard_q, discard_d;

    logic                      q_flush_c, q_alloc_c, q_fill_c, q_pop_c;
    logic                      head_valid_c;
    logic [InstAddressBus-1:0] head_addr_c;
    logic [InstByteBus-1:0]    head_data_c;
    logic [CW-1:0]             alloc_cnt_c;
    logic [CW-1:0]             unfilled_cnt_c;
    logic [SW-1:0]             credit_used_c;
    logic [SW-1:0]             pending_c;
    logic                      accept_c;

    core_ifu_queue #(.DEPTH(DEPTH)) u_queue (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (q_flush_c),
        .alloc_i        (q_alloc_c),
        .alloc_addr_i   (pc_q),
        .fill_i         (q_fill_c),
        .fill_data_i    (mem_rdata_in),
        .pop_i          (q_pop_c),
        .head_valid_c   (head_valid_c),
        .head_addr_c    (head_addr_c),
        .head_data_c    (head_data_c),
        .alloc_cnt_c    (alloc_cnt_c),
        .unfilled_cnt_c (unfilled_cnt_c)
    );

    // Credit counts allocated slots plus fetches still to be thrown away.
    assign credit_used_c = SW'(alloc_cnt_c) + SW'(discard_q);
    assign mem_req_out   = !rst && !jump_en_in && (credit_used_c < SW'(DEPTH));
    assign mem_addr_out  = pc_q;
    assign accept_c      = mem_req_out && mem_ready_in;

    assign inst_valid_out = head_valid_c;
    assign inst_out       = head_valid_c ? head_data_c : INST_NOP;
    assign inst_addr_out  = head_valid_c ? head_addr_c : ZeroWord;

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        q_flush_c = 1'b0;
        q_alloc_c = 1'b0;
        q_fill_c  = 1'b0;
        q_pop_c   = 1'b0;
        pending_c = SW'(unfilled_cnt_c) + SW'(discard_q);

        if (jump_en_in) begin
            // A response landing with the redirect retires one stale fetch immediately.
            pc_d      = word_align(jump_addr_in);
            q_flush_c = 1'b1;
            if (mem_rvalid_in && (pending_c != '0)) begin
                pending_c = pending_c - SW'(1);
            end
            discard_d = CW'(pending_c);
        end else begin
            q_alloc_c = accept_c;
            if (accept_c) begin
                pc_d = pc_q + 32'd4;
            end
            if (mem_rvalid_in) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    q_fill_c = 1'b1;
                end
            end
            q_pop_c = head_valid_c && !stall_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

endmodule

// File: tb/tb_core_ifu.sv
// Directed bench for core_ifu with an in-order memory model and expected-instruction scoreboard.
module tb_core_ifu;
    import core_ifu_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_en_in = 1'b0;
    logic [31:0] jump_addr_in = '0;
    logic        stall_in = 1'b0;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_ready_in = 1'b0;
    logic        mem_rvalid_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_addr_out;

    always #5 clk = ~clk;

    core_ifu #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .jump_en_in     (jump_en_in),
        .jump_addr_in   (jump_addr_in),
        .stall_in       (stall_in),
        .mem_req_out    (mem_req_out),
        .mem_addr_out   (mem_addr_out),
        .mem_ready_in   (mem_ready_in),
        .mem_rvalid_in  (mem_rvalid_in),
        .mem_rdata_in   (mem_rdata_in),
        .inst_valid_out (inst_valid_out),
        .inst_out       (inst_out),
        .inst_addr_out  (inst_addr_out)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_pend[$];
    logic [31:0] exp_pc = '0;
    bit          resp_en = 1'b0;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_iaddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample and score at negedge, update models at posedge, drive next inputs.
    task automatic cycle();
        logic acc, pop, jmp;
        logic [31:0] jaddr;
        @(negedge clk);
        s_req   = mem_req_out;
        s_addr  = mem_addr_out;
        s_valid = inst_valid_out;
        s_iaddr = inst_addr_out;
        if (inst_valid_out) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_valid observed_addr=%h expected=none", inst_addr_out);
            end
            if (exp_q.size() != 0) begin
                check("head_addr", inst_addr_out, exp_q[0]);
                check("head_data", inst_out, exp_q[0] ^ KEY);
            end
        end else begin
            check("idle_inst", inst_out, INST_NOP);
        end
        acc   = mem_req_out && mem_ready_in;
        jmp   = jump_en_in;
        jaddr = jump_addr_in;
        pop   = inst_valid_out && !stall_in && !jump_en_in;
        if (acc) check("fetch_addr", mem_addr_out, exp_pc);
        if (jmp) check("req_in_jump", 32'(mem_req_out), 32'd0);
        @(posedge clk);
        if (acc) mem_pend.push_back(s_addr);
        if (jmp) begin
            exp_q.delete();
            exp_pc = jaddr & ~32'h3;
        end else begin
            if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(s_addr);
                exp_pc = exp_pc + 32'd4;
            end
        end
        #1;
        jump_en_in = 1'b0;
        if (resp_en && mem_pend.size() != 0) begin
            mem_rvalid_in = 1'b1;
            mem_rdata_in  = mem_pend.pop_front() ^ KEY;
        end else begin
            mem_rvalid_in = 1'b0;
            mem_rdata_in  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        mem_rvalid_in = 1'b0;
        jump_en_in    = 1'b0;
        #1;
        check("rst_req", 32'(mem_req_out), 32'd0);
        check("rst_addr", mem_addr_out, 32'h0);
        check("rst_valid", 32'(inst_valid_out), 32'd0);
        check("rst_inst", inst_out, INST_NOP);
        check("rst_iaddr", inst_addr_out, 32'h0);
        exp_q.delete();
        mem_pend.delete();
        exp_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        mem_ready_in = 1'b0;
        resp_en      = 1'b1;
        stall_in     = 1'b0;
        repeat (6) cycle();
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain_left observed=%0d expected=0", exp_q.size());
        end
    endtask

    initial begin
        bit seen;

        // Zero-wait streaming from reset
        #1 do_reset();
        mem_ready_in = 1'b1;
        resp_en      = 1'b1;
        cycle();
        check("first_req", 32'(s_req), 32'd1);
        check("first_addr", s_addr, 32'h0);
        repeat (14) cycle();
        drain();

        // Memory not ready for five cycles
        do_reset();
        mem_ready_in = 1'b0;
        resp_en      = 1'b1;
        repeat (5) begin
            cycle();
            check("wait_addr", s_addr, 32'h0);
            check("wait_valid", 32'(s_valid), 32'd0);
        end
        mem_ready_in = 1'b1;
        repeat (8) cycle();
        drain();

        // Stall with a full queue
        do_reset();
        mem_ready_in = 1'b1;
        resp_en      = 1'b1;
        stall_in     = 1'b1;
        repeat (3) cycle();
        repeat (3) begin
            cycle();
            check("stall_req", 32'(s_req), 32'd0);
            check("stall_head", s_iaddr, 32'h0);
        end
        stall_in     = 1'b0;
        mem_ready_in = 1'b0;
        cycle();
        check("pop_first", s_iaddr, 32'h0);
        cycle();
        check("pop_second", s_iaddr, 32'h4);
        drain();

        // Redirect with two fetches unfilled
        do_reset();
        mem_ready_in = 1'b1;
        resp_en      = 1'b0;
        repeat (3) cycle();
        jump_en_in   = 1'b1;
        jump_addr_in = 32'h0000_0103;
        cycle();
        cycle();
        check("discard_blocks_req", 32'(s_req), 32'd0);
        resp_en = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (s_req) begin
                seen = 1'b1;
                check("redir_addr", s_addr, 32'h0000_0100);
            end
        end
        check("redir_req_seen", 32'(seen), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (s_valid) begin
                seen = 1'b1;
                check("redir_first_valid", s_iaddr, 32'h0000_0100);
            end
        end
        check("redir_valid_seen", 32'(seen), 32'd1);
        repeat (4) cycle();
        drain();

        // Redirect coinciding with a response
        do_reset();
        mem_ready_in = 1'b1;
        resp_en      = 1'b0;
        repeat (2) cycle();
        mem_ready_in = 1'b0;
        resp_en      = 1'b1;
        cycle();
        jump_en_in   = 1'b1;
        jump_addr_in = 32'h0000_0200;
        resp_en      = 1'b0;
        cycle();
        mem_ready_in = 1'b1;
        cycle();
        check("coinc_req", 32'(s_req), 32'd1);
        check("coinc_addr", s_addr, 32'h0000_0200);
        resp_en = 1'b1;
        repeat (8) cycle();
        drain();

        // Redirect near the top of the address space wraps
        jump_en_in   = 1'b1;
        jump_addr_in = 32'hFFFF_FFFE;
        cycle();
        mem_ready_in = 1'b1;
        cycle();
        check("wrap_req", 32'(s_req), 32'd1);
        check("wrap_addr", s_addr, 32'hFFFF_FFFC);
        repeat (6) cycle();
        drain();

        // Reset while fetches are outstanding
        mem_ready_in = 1'b1;
        resp_en      = 1'b1;
        repeat (5) cycle();
        #2 do_reset();
        cycle();
        check("restart_req", 32'(s_req), 32'd1);
        check("restart_addr", s_addr, 32'h0);
        repeat (6) cycle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
